game_sequencer: RTL and testbench

Top-level game-state controller for the Flappy Bruin design. It sits between the board inputs and the `render` datapath. It debounces the flap button and sequences the game through idle, play, death animation and game-over. It also gates physics and scrolling, issues bird/pipe reset pulses, and keeps the BCD current score and high score shown by the renderer.

---
 rtl/game_sequencer_if.sv | 31 +++
 rtl/game_sequencer.sv | 165 ++++++++++++++++
 tb/tb_game_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Board/render-side signal bundle of the game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;
  logic        flap;
  logic        frame_tick;
  logic        collision;
  logic        pipe_passed;
  logic [1:0]  state;
  logic        run;
  logic        flap_pulse;
  logic        bird_reset;
  logic [11:0] score;
  logic [11:0] hi_score;
  logic        new_record;

  // master drives the board/render inputs, slave is the sequencer itself
  modport master (
    output flap, frame_tick, collision, pipe_passed,
    input  state, run, flap_pulse, bird_reset, score, hi_score, new_record
  );

  modport slave (
    input  flap, frame_tick, collision, pipe_passed,
    output state, run, flap_pulse, bird_reset, score, hi_score, new_record
  );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Flap debounce, IDLE/PLAYING/DYING/OVER sequencing, BCD scores.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEATH_FRAMES    = 60,
  parameter int LOCKOUT_FRAMES  = 30
) (
  input  wire             clk_100MHz,
  input  wire             reset,
  game_sequencer_if.slave bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PLAYING = 2'd1;
  localparam logic [1:0] c_DYING   = 2'd2;
  localparam logic [1:0] c_OVER    = 2'd3;

  localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_FMAX    = (DEATH_FRAMES > LOCKOUT_FRAMES) ? DEATH_FRAMES : LOCKOUT_FRAMES;
  localparam int c_FCNT_W  = (c_FMAX < 2) ? 1 : $clog2(c_FMAX + 1);

  localparam logic [c_DB_W-1:0]   c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES);
  localparam logic [c_FCNT_W-1:0] c_DEATH   = c_FCNT_W'(DEATH_FRAMES);
  localparam logic [c_FCNT_W-1:0] c_LOCKOUT = c_FCNT_W'(LOCKOUT_FRAMES);
  localparam logic [c_FCNT_W-1:0] c_FONE    = c_FCNT_W'(1);
  localparam logic [c_FCNT_W-1:0] c_FZERO   = '0;

  logic                r_flap_meta;
  logic                r_flap_sync;
  logic                r_db_level;
  logic [c_DB_W-1:0]   r_db_cnt;
  logic                r_press;

  logic [1:0]          r_state;
  logic                r_run;
  logic                r_flap_pulse;
  logic                r_bird_reset;
  logic [11:0]         r_score;
  logic [11:0]         r_hi_score;
  logic                r_new_record;
  logic [c_FCNT_W-1:0] r_fcnt;

  logic [11:0]         w_score_inc;
  logic                w_hit;

  // Synchronizer, debounce and press edge detector
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_flap_meta <= 1'b0;
      r_flap_sync <= 1'b0;
      r_db_level  <= 1'b0;
      r_db_cnt    <= '0;
      r_press     <= 1'b0;
    end else begin
      r_flap_meta <= bus.flap;
      r_flap_sync <= r_flap_meta;
      r_press     <= 1'b0;
      if (r_flap_sync == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_MAX) begin
        r_db_cnt   <= '0;
        r_db_level <= ~r_db_level;
        r_press    <= ~r_db_level;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // BCD increment; callers guard the 999 saturation point
  always_comb begin
    w_score_inc = r_score;
    if (r_score[3:0] != 4'd9) begin
      w_score_inc[3:0] = r_score[3:0] + 4'd1;
    end else begin
      w_score_inc[3:0] = 4'd0;
      if (r_score[7:4] != 4'd9) begin
        w_score_inc[7:4] = r_score[7:4] + 4'd1;
      end else begin
        w_score_inc[7:4]  = 4'd0;
        w_score_inc[11:8] = r_score[11:8] + 4'd1;
      end
    end
  end

  assign w_hit = bus.frame_tick & bus.collision;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_run        <= 1'b0;
      r_flap_pulse <= 1'b0;
      r_bird_reset <= 1'b0;
      r_score      <= '0;
      r_hi_score   <= '0;
      r_new_record <= 1'b0;
      r_fcnt       <= '0;
    end else begin
      r_flap_pulse <= 1'b0;
      r_bird_reset <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (r_press) begin
            r_state      <= c_PLAYING;
            r_run        <= 1'b1;
            r_bird_reset <= 1'b1;
            r_score      <= '0;
          end
        end
        c_PLAYING: begin
          r_flap_pulse <= r_press;
          if (bus.pipe_passed && (r_score != 12'h999)) begin
            r_score <= w_score_inc;
          end
          if (w_hit) begin
            r_state <= c_DYING;
            r_run   <= 1'b0;
            r_fcnt  <= c_DEATH;
          end
        end
        c_DYING: begin
          if (bus.frame_tick) begin
            if (r_fcnt == c_FONE) begin
              r_state <= c_OVER;
              r_fcnt  <= c_LOCKOUT;
              // BCD digits order the same way as binary, so a plain compare works
              if (r_score > r_hi_score) begin
                r_hi_score   <= r_score;
                r_new_record <= 1'b1;
              end else begin
                r_new_record <= 1'b0;
              end
            end else begin
              r_fcnt <= r_fcnt - 1'b1;
            end
          end
        end
        default: begin
          if (bus.frame_tick && (r_fcnt != c_FZERO)) begin
            r_fcnt <= r_fcnt - 1'b1;
          end
          if (r_press && (r_fcnt == c_FZERO)) begin
            r_state      <= c_IDLE;
            r_bird_reset <= 1'b1;
            r_new_record <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.run        = r_run;
  assign bus.flap_pulse = r_flap_pulse;
  assign bus.bird_reset = r_bird_reset;
  assign bus.score      = r_score;
  assign bus.hi_score   = r_hi_score;
  assign bus.new_record = r_new_record;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer (D=4, 3, 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  logic clk_100MHz = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_fp;
  int   n_br;

  game_sequencer_if g ();

  game_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .DEATH_FRAMES   (3),
    .LOCKOUT_FRAMES (2)
  ) u_dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .bus       (g)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check_value(input string tag, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", tag, act, req);
    end
  endtask

  // inputs change and outputs are sampled 1 ns after each rising edge
  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      g.frame_tick = 1'b1;
      cyc();
      g.frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic pipes(input int n);
    g.pipe_passed = 1'b1;
    repeat (n) cyc();
    g.pipe_passed = 1'b0;
  endtask

  // 10-cycle press then 8-cycle release; counts output pulses seen
  task automatic do_press(output int fp, output int br);
    fp = 0;
    br = 0;
    g.flap = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) g.flap = 1'b0;
      cyc();
      fp += int'(g.flap_pulse);
      br += int'(g.bird_reset);
    end
  endtask

  initial begin
    g.flap        = 1'b0;
    g.frame_tick  = 1'b0;
    g.collision   = 1'b0;
    g.pipe_passed = 1'b0;
    reset         = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    check_value("rst_state",  {10'd0, g.state}, 12'h000);
    check_value("rst_run",    {11'd0, g.run}, 12'h000);
    check_value("rst_fp",     {11'd0, g.flap_pulse}, 12'h000);
    check_value("rst_br",     {11'd0, g.bird_reset}, 12'h000);
    check_value("rst_score",  g.score, 12'h000);
    check_value("rst_hi",     g.hi_score, 12'h000);
    check_value("rst_nr",     {11'd0, g.new_record}, 12'h000);

    // collision/pipe events in IDLE do nothing
    g.collision = 1'b1; g.frame_tick = 1'b1; g.pipe_passed = 1'b1;
    cyc();
    g.collision = 1'b0; g.frame_tick = 1'b0; g.pipe_passed = 1'b0;
    cyc();
    check_value("idle_ev_state", {10'd0, g.state}, 12'h000);
    check_value("idle_ev_score", g.score, 12'h000);

    // 3-cycle glitch must be swallowed by the debouncer
    g.flap = 1'b1;
    repeat (3) cyc();
    g.flap = 1'b0;
    repeat (10) cyc();
    check_value("glitch_state", {10'd0, g.state}, 12'h000);

    // start press: transition and bird_reset exactly at edge N+7
    n_br = 0;
    g.flap = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      if (i == 11) g.flap = 1'b0;
      cyc();
      n_br += int'(g.bird_reset);
      if (i == 7) begin
        check_value("start_n6_state", {10'd0, g.state}, 12'h000);
        check_value("start_n6_br",    {11'd0, g.bird_reset}, 12'h000);
      end
      if (i == 8) begin
        check_value("start_n7_state", {10'd0, g.state}, 12'h001);
        check_value("start_n7_br",    {11'd0, g.bird_reset}, 12'h001);
        check_value("start_n7_run",   {11'd0, g.run}, 12'h001);
        check_value("start_n7_fp",    {11'd0, g.flap_pulse}, 12'h000);
      end
      if (i == 9) check_value("start_n8_br", {11'd0, g.bird_reset}, 12'h000);
    end
    check_value("start_br_count", 12'(n_br), 12'h001);
    check_value("start_score",    g.score, 12'h000);

    // a press while playing is a single flap
    do_press(n_fp, n_br);
    check_value("play_fp_count", 12'(n_fp), 12'h001);
    check_value("play_br_count", 12'(n_br), 12'h000);

    // game 1: 4 pipes, then pipe + collision on a frame tick
    pipes(4);
    cyc();
    check_value("g1_score4", g.score, 12'h004);
    g.collision = 1'b1;
    repeat (3) cyc();
    check_value("coll_no_tick", {10'd0, g.state}, 12'h001);
    g.frame_tick = 1'b1; g.pipe_passed = 1'b1;
    cyc();
    g.frame_tick = 1'b0; g.pipe_passed = 1'b0; g.collision = 1'b0;
    check_value("g1_dying",  {10'd0, g.state}, 12'h002);
    check_value("g1_run0",   {11'd0, g.run}, 12'h000);
    check_value("g1_score5", g.score, 12'h005);

    do_press(n_fp, n_br);
    check_value("dying_press_fp", 12'(n_fp), 12'h000);
    check_value("dying_press_st", {10'd0, g.state}, 12'h002);
    pipes(2);
    check_value("dying_pipe_ign", g.score, 12'h005);
    tick_frames(2);
    check_value("g1_dying2", {10'd0, g.state}, 12'h002);
    tick_frames(1);
    check_value("g1_over", {10'd0, g.state}, 12'h003);
    check_value("g1_hi",   g.hi_score, 12'h005);
    check_value("g1_nr",   {11'd0, g.new_record}, 12'h001);

    // lockout: press before two ticks ignored
    do_press(n_fp, n_br);
    check_value("lock_press_st", {10'd0, g.state}, 12'h003);
    check_value("lock_press_br", 12'(n_br), 12'h000);
    tick_frames(1);
    do_press(n_fp, n_br);
    check_value("lock1_press_st", {10'd0, g.state}, 12'h003);
    tick_frames(1);
    do_press(n_fp, n_br);
    check_value("over_exit_st",  {10'd0, g.state}, 12'h000);
    check_value("over_exit_br",  12'(n_br), 12'h001);
    check_value("over_keep_scr", g.score, 12'h005);

    // game 2: start clears score, then 3 pipes, press coincident with a hit
    do_press(n_fp, n_br);
    check_value("g2_state", {10'd0, g.state}, 12'h001);
    check_value("g2_clear", g.score, 12'h000);
    pipes(3);
    g.flap = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      if (i == 11) g.flap = 1'b0;
      if (i == 8) begin
        g.collision = 1'b1; g.frame_tick = 1'b1;
      end
      cyc();
      if (i == 8) begin
        g.collision = 1'b0; g.frame_tick = 1'b0;
        check_value("g2_hit_fp",    {11'd0, g.flap_pulse}, 12'h001);
        check_value("g2_hit_state", {10'd0, g.state}, 12'h002);
      end
    end
    tick_frames(3);
    check_value("g2_over",  {10'd0, g.state}, 12'h003);
    check_value("g2_score", g.score, 12'h003);
    check_value("g2_hi",    g.hi_score, 12'h005);
    check_value("g2_nr",    {11'd0, g.new_record}, 12'h000);
    tick_frames(2);
    do_press(n_fp, n_br);
    check_value("g2_exit_st", {10'd0, g.state}, 12'h000);

    // game 3: BCD carry and 999 saturation
    do_press(n_fp, n_br);
    pipes(12);
    check_value("g3_score12",  g.score, 12'h012);
    pipes(986);
    check_value("g3_score998", g.score, 12'h998);
    pipes(3);
    check_value("g3_score999", g.score, 12'h999);
    g.collision = 1'b1; g.frame_tick = 1'b1;
    cyc();
    g.collision = 1'b0; g.frame_tick = 1'b0;
    tick_frames(1);
    check_value("g3_dying", {10'd0, g.state}, 12'h002);

    // reset mid-DYING
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_value("mid_rst_state", {10'd0, g.state}, 12'h000);
    check_value("mid_rst_score", g.score, 12'h000);
    check_value("mid_rst_hi",    g.hi_score, 12'h000);
    check_value("mid_rst_nr",    {11'd0, g.new_record}, 12'h000);
    check_value("mid_rst_run",   {11'd0, g.run}, 12'h000);
    check_value("mid_rst_br",    {11'd0, g.bird_reset}, 12'h000);
    pipes(2);
    g.collision = 1'b1; g.frame_tick = 1'b1;
    cyc();
    g.collision = 1'b0; g.frame_tick = 1'b0;
    check_value("post_rst_state", {10'd0, g.state}, 12'h000);
    check_value("post_rst_score", g.score, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
